// File: rtl/rx_frame_if.sv
// Parser/CPU-side signal bundle for rx_frame_ctrl.
// The controller uses the slave modport. A parser/CPU model uses the master modport.
interface rx_frame_if #(
  parameter int OCT     = 8,
  parameter int SLOT_AW = 11
);
  logic               rx_ethernet_data_v;
  logic [OCT-1:0]     rx_ethernet_data;
  logic               rx_ethernet_irq;
  logic               rx_frame_avail;
  logic [SLOT_AW:0]   rx_frame_len;
  logic [SLOT_AW-1:0] rx_rd_addr;
  logic [OCT-1:0]     rx_rd_data;
  logic               rx_frame_pop;
  logic               rx_frame_irq;
  logic [15:0]        rx_drop_cnt;

  modport slave (
    input  rx_ethernet_data_v, rx_ethernet_data, rx_ethernet_irq, rx_rd_addr, rx_frame_pop,
    output rx_frame_avail, rx_frame_len, rx_rd_data, rx_frame_irq, rx_drop_cnt
  );

  modport master (
    output rx_ethernet_data_v, rx_ethernet_data, rx_ethernet_irq, rx_rd_addr, rx_frame_pop,
    input  rx_frame_avail, rx_frame_len, rx_rd_data, rx_frame_irq, rx_drop_cnt
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive frame buffer controller: parser bytes go into a ring of fixed-size RAM slots.
// Committed frames are handed to the CPU through a slot read port with pop/release.
module rx_frame_ctrl #(
  parameter int OCT     = 8,
  parameter int SLOTS   = 4,
  parameter int SLOT_AW = 11
) (
  input  logic        RX_CLK,
  input  logic        rst,
  rx_frame_if.slave   bus
);
  localparam int SW = $clog2(SLOTS);
  localparam int LW = SLOT_AW + 1;
  localparam logic [LW-1:0] CAP  = LW'(1) << SLOT_AW;
  localparam logic [SW:0]   FULL = (SW+1)'(SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      wr_slot_q, rd_slot_q;
  logic [SW:0]        frm_cnt_q;
  logic [LW-1:0]      wr_len_q, wr_len_d;
  logic [15:0]        drop_cnt_q;
  logic               frame_irq_q;
  logic               data_v_q;
  logic [OCT-1:0]     rd_data_q;
  logic [LW-1:0]      len_table_q [SLOTS];
  logic [OCT-1:0]     mem_q [SLOTS << SLOT_AW];

  logic               start, full, pop_ok;
  logic               wr_en, commit, drop_inc;
  logic [SW+SLOT_AW-1:0] wr_addr, rd_addr;

  // A frame may only begin on a data_v rising edge, so a frame cut by reset is never resumed mid-way.
  assign start   = bus.rx_ethernet_data_v && !data_v_q;
  assign full    = (frm_cnt_q == FULL);
  assign pop_ok  = bus.rx_frame_pop && (frm_cnt_q != '0);
  assign wr_addr = {wr_slot_q, wr_len_q[SLOT_AW-1:0]};
  assign rd_addr = {rd_slot_q, bus.rx_rd_addr};

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = full ? ST_DROP : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.rx_ethernet_irq) begin
          state_d = ST_IDLE;
        end else if (bus.rx_ethernet_data_v && (wr_len_q == CAP)) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.rx_ethernet_irq) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // wr_len is kept at zero whenever no frame is being stored, so the first byte lands at offset 0.
  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    wr_len_d = wr_len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (full) begin
            drop_inc = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_len_d = LW'(1);
          end
        end
      end
      ST_WRITE: begin
        if (bus.rx_ethernet_irq) begin
          commit   = 1'b1;
          wr_len_d = '0;
        end else if (bus.rx_ethernet_data_v) begin
          if (wr_len_q == CAP) begin
            drop_inc = 1'b1;
            wr_len_d = '0;
          end else begin
            wr_en    = 1'b1;
            wr_len_d = wr_len_q + LW'(1);
          end
        end
      end
      ST_DROP: wr_len_d = wr_len_q;
      default: wr_len_d = '0;
    endcase
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      wr_slot_q   <= '0;
      rd_slot_q   <= '0;
      frm_cnt_q   <= '0;
      wr_len_q    <= '0;
      drop_cnt_q  <= '0;
      frame_irq_q <= 1'b0;
      data_v_q    <= 1'b1;
    end else begin
      wr_len_q    <= wr_len_d;
      frame_irq_q <= commit;
      data_v_q    <= bus.rx_ethernet_data_v;
      if (commit) begin
        wr_slot_q <= wr_slot_q + SW'(1);
      end
      if (pop_ok) begin
        rd_slot_q <= rd_slot_q + SW'(1);
      end
      if (commit && !pop_ok) begin
        frm_cnt_q <= frm_cnt_q + (SW+1)'(1);
      end else if (!commit && pop_ok) begin
        frm_cnt_q <= frm_cnt_q - (SW+1)'(1);
      end
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_len
    always_ff @(posedge RX_CLK) begin
      if (rst) begin
        len_table_q[gi] <= '0;
      end else if (commit && (wr_slot_q == SW'(gi))) begin
        len_table_q[gi] <= wr_len_q;
      end
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= bus.rx_ethernet_data;
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign bus.rx_frame_avail = (frm_cnt_q != '0);
  assign bus.rx_frame_len   = len_table_q[rd_slot_q];
  assign bus.rx_rd_data     = rd_data_q;
  assign bus.rx_frame_irq   = frame_irq_q;
  assign bus.rx_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: a frame-queue reference model checked every cycle, plus directed literal checks.
module tb_rx_frame_ctrl;
  localparam int SLOTS = 4;
  localparam int CAPB  = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_frame_if #(.OCT(8), .SLOT_AW(11)) bus ();

  rx_frame_ctrl #(.OCT(8), .SLOTS(SLOTS), .SLOT_AW(11)) dut (
    .RX_CLK (clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    int         len;
    logic [7:0] seed;
    logic [7:0] step;
  } frm_t;

  int n_assert = 0;
  int n_fail   = 0;
  int irq_seen = 0;

  // reference model state
  frm_t       mq[$];
  frm_t       cur_f;
  logic [7:0] drv_seed, drv_step;
  int         mode;          // 0 no frame, 1 storing, 2 discarding
  logic [15:0] m_drops;
  logic       m_irq, m_prev_v, m_rd_ok, model_live = 1'b0;
  logic [7:0] m_rd;
  bit         rand_pop  = 1'b0;
  bit         hold_addr = 1'b0;

  function automatic logic [7:0] fbyte(logic [7:0] s, logic [7:0] st, int off);
    logic [7:0] o;
    o = off[7:0];
    return 8'(s + st * o);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int cnt;
    if (rst) begin
      mq.delete();
      mode       = 0;
      m_drops    = '0;
      m_irq      = 1'b0;
      m_prev_v   = 1'b1;
      m_rd_ok    = 1'b0;
      model_live = 1'b1;
    end else begin
      cnt     = mq.size();
      m_rd_ok = 1'b0;
      if (cnt > 0 && int'(bus.rx_rd_addr) < mq[0].len) begin
        m_rd_ok = 1'b1;
        m_rd    = fbyte(mq[0].seed, mq[0].step, int'(bus.rx_rd_addr));
      end
      m_irq = 1'b0;
      case (mode)
        0: if (bus.rx_ethernet_data_v && !m_prev_v) begin
             if (cnt == SLOTS) begin
               mode = 2;
               if (m_drops != 16'hFFFF) m_drops++;
             end else begin
               mode       = 1;
               cur_f.len  = 1;
               cur_f.seed = drv_seed;
               cur_f.step = drv_step;
             end
           end
        1: if (bus.rx_ethernet_irq) begin
             mq.push_back(cur_f);
             m_irq = 1'b1;
             mode  = 0;
           end else if (bus.rx_ethernet_data_v) begin
             if (cur_f.len == CAPB) begin
               mode = 2;
               if (m_drops != 16'hFFFF) m_drops++;
             end else begin
               cur_f.len++;
             end
           end
        default: if (bus.rx_ethernet_irq) mode = 0;
      endcase
      if (bus.rx_frame_pop && cnt > 0) void'(mq.pop_front());
      m_prev_v = bus.rx_ethernet_data_v;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("avail", 32'(bus.rx_frame_avail), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("frame_len", 32'(bus.rx_frame_len), 32'(mq[0].len));
      chk("frame_irq", 32'(bus.rx_frame_irq), 32'(m_irq));
      chk("drop_cnt", 32'(bus.rx_drop_cnt), 32'(m_drops));
      if (m_rd_ok) chk("rd_data", 32'(bus.rx_rd_data), 32'(m_rd));
      if (bus.rx_frame_irq) irq_seen++;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (!hold_addr) bus.rx_rd_addr = 11'($urandom_range(0, 255));
    bus.rx_frame_pop = rand_pop && ($urandom_range(0, 5) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.rx_ethernet_data_v = 1'b0;
      bus.rx_ethernet_irq    = 1'b0;
    end
  endtask

  task automatic send_frame(input int len, input logic [7:0] seed, input logic [7:0] step,
                            input bit pop_first, input bit pop_irq);
    drv_seed = seed;
    drv_step = step;
    for (int i = 0; i < len; i++) begin
      tick();
      bus.rx_ethernet_irq    = 1'b0;
      bus.rx_ethernet_data_v = 1'b1;
      bus.rx_ethernet_data   = fbyte(seed, step, i);
      if (i == 0 && pop_first) bus.rx_frame_pop = 1'b1;
    end
    tick();
    bus.rx_ethernet_data_v = 1'b0;
    bus.rx_ethernet_irq    = 1'b1;
    if (pop_irq) bus.rx_frame_pop = 1'b1;
  endtask

  task automatic pop_once();
    tick();
    bus.rx_frame_pop = 1'b1;
    idle(1);
  endtask

  task automatic pulse_rst();
    tick();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_irq, base_drop;
    int lens[5];
    bus.rx_ethernet_data_v = 1'b0;
    bus.rx_ethernet_data   = '0;
    bus.rx_ethernet_irq    = 1'b0;
    bus.rx_rd_addr         = '0;
    bus.rx_frame_pop       = 1'b0;
    drv_seed = '0;
    drv_step = 8'd1;
    idle(3);
    chk("rst_avail", 32'(bus.rx_frame_avail), 0);
    chk("rst_len", 32'(bus.rx_frame_len), 0);
    chk("rst_rd_data", 32'(bus.rx_rd_data), 0);
    chk("rst_irq", 32'(bus.rx_frame_irq), 0);
    chk("rst_drop", 32'(bus.rx_drop_cnt), 0);
    rst = 1'b0;
    idle(2);

    // single 60-byte frame 00..3B
    base_irq = irq_seen;
    send_frame(60, 8'h00, 8'h01, 1'b0, 1'b0);
    idle(3);
    chk("t1_irqs", 32'(irq_seen - base_irq), 1);
    chk("t1_avail", 32'(bus.rx_frame_avail), 1);
    chk("t1_len", 32'(bus.rx_frame_len), 60);
    hold_addr = 1'b1;
    for (int a = 0; a <= 60; a++) begin
      tick();
      if (a > 0) chk("t1_byte", 32'(bus.rx_rd_data), 32'(a - 1));
      if (a < 60) bus.rx_rd_addr = 11'(a);
    end
    hold_addr = 1'b0;
    pop_once();
    chk("t1_pop_avail", 32'(bus.rx_frame_avail), 0);

    // five 64-byte frames, no pops
    base_irq = irq_seen;
    for (int f = 0; f < 5; f++) begin
      send_frame(64, 8'($urandom), 8'($urandom) | 8'h01, 1'b0, 1'b0);
      idle(1);
    end
    idle(2);
    chk("t2_irqs", 32'(irq_seen - base_irq), 4);
    chk("t2_drop", 32'(bus.rx_drop_cnt), 1);
    for (int k = 0; k < 4; k++) begin
      chk("t2_pop_len", 32'(bus.rx_frame_len), 64);
      pop_once();
    end
    chk("t2_empty", 32'(bus.rx_frame_avail), 0);

    // oversize 2049-byte frame, then a 100-byte frame
    pulse_rst();
    base_irq = irq_seen;
    send_frame(CAPB + 1, 8'h5A, 8'h03, 1'b0, 1'b0);
    idle(3);
    chk("t3_drop", 32'(bus.rx_drop_cnt), 1);
    chk("t3_irqs", 32'(irq_seen - base_irq), 0);
    chk("t3_avail", 32'(bus.rx_frame_avail), 0);
    send_frame(100, 8'h11, 8'h07, 1'b0, 1'b0);
    idle(3);
    chk("t3_len", 32'(bus.rx_frame_len), 100);
    pop_once();

    // commit and pop in the same cycle, then a pop on a full ring's first byte
    base_irq  = irq_seen;
    base_drop = int'(bus.rx_drop_cnt);
    for (int f = 0; f < 5; f++) lens[f] = int'($urandom_range(10, 70));
    for (int f = 0; f < 3; f++) begin
      send_frame(lens[f], 8'($urandom), 8'($urandom) | 8'h01, 1'b0, 1'b0);
      idle(1);
    end
    send_frame(lens[3], 8'($urandom), 8'($urandom) | 8'h01, 1'b0, 1'b1);
    idle(2);
    chk("t4_head_after_simul", 32'(bus.rx_frame_len), 32'(lens[1]));
    send_frame(lens[4], 8'($urandom), 8'($urandom) | 8'h01, 1'b0, 1'b0);
    idle(2);
    send_frame(30, 8'($urandom), 8'h01, 1'b1, 1'b0);
    idle(2);
    chk("t4_irqs", 32'(irq_seen - base_irq), 5);
    chk("t4_drop", 32'(bus.rx_drop_cnt), 32'(base_drop + 1));
    for (int k = 2; k < 5; k++) begin
      chk("t4_order", 32'(bus.rx_frame_len), 32'(lens[k]));
      pop_once();
    end
    chk("t4_empty", 32'(bus.rx_frame_avail), 0);

    // reset in the middle of a 200-byte frame
    drv_seed = 8'h20;
    drv_step = 8'h01;
    for (int i = 0; i < 200; i++) begin
      tick();
      bus.rx_ethernet_irq    = 1'b0;
      bus.rx_ethernet_data_v = 1'b1;
      bus.rx_ethernet_data   = fbyte(8'h20, 8'h01, i);
      if (i == 100) rst = 1'b1;
      if (i == 101) begin
        chk("t5_avail", 32'(bus.rx_frame_avail), 0);
        chk("t5_len", 32'(bus.rx_frame_len), 0);
        chk("t5_rd_data", 32'(bus.rx_rd_data), 0);
        chk("t5_irq", 32'(bus.rx_frame_irq), 0);
        chk("t5_drop", 32'(bus.rx_drop_cnt), 0);
      end
      if (i == 102) rst = 1'b0;
    end
    tick();
    bus.rx_ethernet_data_v = 1'b0;
    bus.rx_ethernet_irq    = 1'b1;
    idle(3);
    chk("t5_tail_avail", 32'(bus.rx_frame_avail), 0);
    chk("t5_tail_drop", 32'(bus.rx_drop_cnt), 0);
    send_frame(60, 8'h40, 8'h02, 1'b0, 1'b0);
    idle(3);
    chk("t5_len60", 32'(bus.rx_frame_len), 60);
    pop_once();

    // stray pops and a zero-payload irq
    base_irq  = irq_seen;
    base_drop = int'(bus.rx_drop_cnt);
    for (int k = 0; k < 3; k++) pop_once();
    tick();
    bus.rx_ethernet_irq = 1'b1;
    idle(3);
    chk("t6_irqs", 32'(irq_seen - base_irq), 0);
    chk("t6_drop", 32'(bus.rx_drop_cnt), 32'(base_drop));
    chk("t6_avail", 32'(bus.rx_frame_avail), 0);

    // randomized traffic with random pops, including 2048- and 2049-byte frames
    rand_pop = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = (f == 10) ? CAPB : (f == 20) ? CAPB + 1 : int'($urandom_range(1, 150));
      send_frame(len, 8'($urandom), 8'($urandom) | 8'h01, 1'b0, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);
    rand_pop = 1'b0;
    for (int k = 0; k < 8; k++) pop_once();
    chk("t7_drained", 32'(bus.rx_frame_avail), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
